// File: rtl/updown_counter_ctrl.sv
// Command-driven sequencer for the 4-bit up/down bounce counter: bounds, mode, prescaled ticks.
// Optional sticky reversal/wrap interrupt (irq, irq_clr) is built only when UDC_REVERSAL_IRQ_EN is defined.
//
// state    | meaning
// IDLE  00 | stopped; LOAD applies configuration, START begins counting
// RUN   01 | prescaler advances while en=1, count moves on each tick
// PAUSE 10 | prescaler and count held; START resumes from held prescaler
module updown_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 100000000,
    parameter int DIV_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_lo,
    input  logic [WIDTH-1:0] cmd_hi,
    input  logic             cmd_wrap,
    input  logic             cmd_dir,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tick,
    output logic [1:0]       state_o,
`ifdef UDC_REVERSAL_IRQ_EN
    output logic             irq,
    input  logic             irq_clr,
`endif
    output logic             cmd_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               dir_q, dir_d;
    logic               cfg_dir_q, cfg_dir_d;
    logic               wrap_q, wrap_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               cmd_err_q, cmd_err_d;

    logic               accept;
    logic               load_ok;
    logic               presc_run;
    logic               tick_due;
    logic               tick_ok;
    logic               turn;

    assign accept    = cmd_valid & cmd_ready_q;
    assign load_ok   = (cmd_lo <= cmd_hi);
    assign presc_run = (state_q == ST_RUN) && en;
    assign tick_due  = presc_run && (presc_q == PRESC_MAX);

    // A STOP or PAUSE landing on the tick edge takes priority and swallows the update.
    assign tick_ok = tick_due &&
                     !(accept && ((cmd_op == OP_STOP) || (cmd_op == OP_PAUSE)));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        dir_d       = dir_q;
        cfg_dir_d   = cfg_dir_q;
        wrap_d      = wrap_q;
        presc_d     = presc_q;
        cmd_ready_d = ~accept;
        cmd_err_d   = 1'b0;
        turn        = 1'b0;

        if (presc_run) begin
            presc_d = tick_due ? '0 : presc_q + DIV_W'(1);
        end

        if (tick_ok) begin
            if (lo_q == hi_q) begin
                count_d = lo_q;
            end else if (wrap_q) begin
                if (dir_q) begin
                    if (count_q >= hi_q) begin
                        count_d = lo_q;
                        turn    = 1'b1;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end else begin
                    if (count_q <= lo_q) begin
                        count_d = hi_q;
                        turn    = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
            end else begin
                // Bounce: at a bound reverse and step one inside, so [lo,hi] is never left.
                if (dir_q) begin
                    if (count_q >= hi_q) begin
                        dir_d   = 1'b0;
                        count_d = hi_q - ONE;
                        turn    = 1'b1;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end else begin
                    if (count_q <= lo_q) begin
                        dir_d   = 1'b1;
                        count_d = lo_q + ONE;
                        turn    = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
            end
        end

        if (accept) begin
            if (cmd_op == OP_STOP) begin
                state_d = ST_IDLE;
                count_d = lo_q;
                dir_d   = cfg_dir_q;
                presc_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        case (cmd_op)
                            OP_START: begin
                                state_d = ST_RUN;
                                presc_d = '0;
                            end
                            OP_LOAD: begin
                                if (load_ok) begin
                                    lo_d      = cmd_lo;
                                    hi_d      = cmd_hi;
                                    wrap_d    = cmd_wrap;
                                    cfg_dir_d = cmd_dir;
                                    dir_d     = cmd_dir;
                                    count_d   = cmd_lo;
                                    presc_d   = '0;
                                end else begin
                                    cmd_err_d = 1'b1;
                                end
                            end
                            default: cmd_err_d = 1'b1;
                        endcase
                    end
                    ST_RUN: begin
                        case (cmd_op)
                            OP_PAUSE: state_d   = ST_PAUSE;
                            OP_LOAD:  cmd_err_d = 1'b1;
                            default:  ;
                        endcase
                    end
                    ST_PAUSE: begin
                        case (cmd_op)
                            OP_START: state_d   = ST_RUN;
                            OP_LOAD:  cmd_err_d = 1'b1;
                            default:  ;
                        endcase
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '1;
            dir_q       <= 1'b1;
            cfg_dir_q   <= 1'b1;
            wrap_q      <= 1'b0;
            presc_q     <= '0;
            cmd_ready_q <= 1'b1;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            dir_q       <= dir_d;
            cfg_dir_q   <= cfg_dir_d;
            wrap_q      <= wrap_d;
            presc_q     <= presc_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

`ifdef UDC_REVERSAL_IRQ_EN
    logic irq_q;

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (tick_ok && turn) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

    assign cmd_ready = cmd_ready_q;
    assign cmd_err   = cmd_err_q;
    assign count     = count_q;
    assign dir       = dir_q;
    assign tick      = tick_ok;
    assign state_o   = state_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Scoreboard bench for updown_counter_ctrl at WIDTH=4, DIV=4: expected count/dir per tick
// are queued when commands are issued and popped when the DUT ticks.
module tb_updown_counter_ctrl;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int DIV_W = 28;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_lo;
    logic [WIDTH-1:0] cmd_hi;
    logic             cmd_wrap;
    logic             cmd_dir;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             tick;
    logic [1:0]       state_o;
    logic             cmd_err;

    typedef struct packed {
        logic [WIDTH-1:0] c;
        logic             d;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    bit   sb_on       = 1'b0;
    bit   chk_pending = 1'b0;
    int   tick_cnt    = 0;

    updown_counter_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_wrap(cmd_wrap), .cmd_dir(cmd_dir),
        .count(count), .dir(dir), .tick(tick), .state_o(state_o), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [WIDTH-1:0] c, input logic d);
        exp_t e;
        e.c = c;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // A tick seen at one falling edge is checked against the queue at the next one,
    // after the count has been updated by the intervening rising edge.
    task automatic sb_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_pending) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_tick count=%0d dir=%0d required no tick", count, dir);
                end else begin
                    e = exp_q.pop_front();
                    if (count !== e.c || dir !== e.d) begin
                        errors++;
                        $display("FAIL sb_tick_update count=%0d dir=%0d required count=%0d dir=%0d",
                                 count, dir, e.c, e.d);
                    end
                end
            end
            if (tick === 1'b1) tick_cnt++;
            chk_pending = sb_on && (tick === 1'b1);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] lo,
                            input logic [WIDTH-1:0] hi, input logic w, input logic d);
        int guard;
        guard    = 0;
        cmd_op   = op;
        cmd_lo   = lo;
        cmd_hi   = hi;
        cmd_wrap = w;
        cmd_dir  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_sb(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || chk_pending) && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cmd_valid = 1'b0;
        cmd_op = OP_STOP; cmd_lo = '0; cmd_hi = '0; cmd_wrap = 1'b0; cmd_dir = 1'b0;
        step(3);
        rst = 1'b0;
        checks++;
        if (state_o !== 2'b00 || count !== 4'd0 || dir !== 1'b1) begin
            errors++;
            $display("FAIL reset_state state=%0d count=%0d dir=%b required 0 0 1", state_o, count, dir);
        end
        checks++;
        if (cmd_ready !== 1'b1 || cmd_err !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs ready=%b err=%b tick=%b required 1 0 0", cmd_ready, cmd_err, tick);
        end
    endtask

    task automatic test_start();
        int n;
        int n2;
        sb_on = 1'b1;
        push(4'd1, 1'b1);
        push(4'd2, 1'b1);
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (state_o !== 2'b01) begin
            errors++;
            $display("FAIL start_state state=%0d required 1", state_o);
        end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL first_tick_latency cycles=%0d required 4", n);
        end
        n2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin n2 = i; break; end
        end
        checks++;
        if (n2 != 4) begin
            errors++;
            $display("FAIL tick_period cycles=%0d required 4", n2);
        end
        wait_sb(40);
        send_cmd(OP_STOP, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (state_o !== 2'b00 || count !== 4'd0 || dir !== 1'b1) begin
            errors++;
            $display("FAIL stop_restore state=%0d count=%0d dir=%b required 0 0 1", state_o, count, dir);
        end
    endtask

    task automatic test_bounce();
        send_cmd(OP_LOAD, 4'd3, 4'd5, 1'b0, 1'b1);
        checks++;
        if (count !== 4'd3 || dir !== 1'b1 || cmd_err !== 1'b0 || state_o !== 2'b00) begin
            errors++;
            $display("FAIL bounce_load count=%0d dir=%b err=%b state=%0d required 3 1 0 0",
                     count, dir, cmd_err, state_o);
        end
        push(4'd4, 1'b1); push(4'd5, 1'b1); push(4'd4, 1'b0); push(4'd3, 1'b0); push(4'd4, 1'b1);
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_sb(200);
        send_cmd(OP_STOP, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd3 || dir !== 1'b1) begin
            errors++;
            $display("FAIL bounce_stop count=%0d dir=%b required 3 1", count, dir);
        end
    endtask

    task automatic test_wrap();
        send_cmd(OP_LOAD, 4'd2, 4'd4, 1'b1, 1'b0);
        checks++;
        if (count !== 4'd2 || dir !== 1'b0) begin
            errors++;
            $display("FAIL wrap_load count=%0d dir=%b required 2 0", count, dir);
        end
        push(4'd4, 1'b0); push(4'd3, 1'b0); push(4'd2, 1'b0); push(4'd4, 1'b0);
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_sb(200);
        send_cmd(OP_STOP, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd2 || dir !== 1'b0) begin
            errors++;
            $display("FAIL wrap_stop count=%0d dir=%b required 2 0", count, dir);
        end
    endtask

    task automatic test_reject();
        send_cmd(OP_LOAD, 4'd9, 4'd5, 1'b0, 1'b1);
        checks++;
        if (cmd_err !== 1'b1 || cmd_ready !== 1'b0 || count !== 4'd2) begin
            errors++;
            $display("FAIL bad_load err=%b ready=%b count=%0d required 1 0 2", cmd_err, cmd_ready, count);
        end
        step(1);
        checks++;
        if (cmd_err !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse err=%b ready=%b required 0 1", cmd_err, cmd_ready);
        end
        send_cmd(OP_PAUSE, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (cmd_err !== 1'b1 || state_o !== 2'b00) begin
            errors++;
            $display("FAIL pause_in_idle err=%b state=%0d required 1 0", cmd_err, state_o);
        end
        push(4'd4, 1'b0); push(4'd3, 1'b0);
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        step(1);
        send_cmd(OP_LOAD, 4'd0, 4'd15, 1'b0, 1'b1);
        checks++;
        if (cmd_err !== 1'b1 || state_o !== 2'b01) begin
            errors++;
            $display("FAIL load_in_run err=%b state=%0d required 1 1", cmd_err, state_o);
        end
        wait_sb(200);
        send_cmd(OP_STOP, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd2 || dir !== 1'b0) begin
            errors++;
            $display("FAIL cfg_kept count=%0d dir=%b required 2 0", count, dir);
        end
    endtask

    task automatic test_pause_en();
        int t0;
        send_cmd(OP_LOAD, 4'd0, 4'd15, 1'b0, 1'b1);
        push(4'd1, 1'b1);
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        step(2);
        send_cmd(OP_PAUSE, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (state_o !== 2'b10 || count !== 4'd0) begin
            errors++;
            $display("FAIL pause_enter state=%0d count=%0d required 2 0", state_o, count);
        end
        t0 = tick_cnt;
        step(10);
        checks++;
        if (tick_cnt != t0 || count !== 4'd0) begin
            errors++;
            $display("FAIL pause_hold ticks=%0d count=%0d required 0 0", tick_cnt - t0, count);
        end
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick tick=%b required 1", tick);
        end
        wait_sb(40);
        en = 1'b0;
        t0 = tick_cnt;
        step(8);
        checks++;
        if (tick_cnt != t0 || count !== 4'd1) begin
            errors++;
            $display("FAIL en_low ticks=%0d count=%0d required 0 1", tick_cnt - t0, count);
        end
        en = 1'b1;
        push(4'd2, 1'b1);
        wait_sb(100);
    endtask

    task automatic test_collision();
        bit found;
        sb_on = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (tick === 1'b1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL collide_find tick=%b required 1", tick);
        end
        cmd_op = OP_PAUSE;
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL collide_tick tick=%b required 0", tick);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if (count !== 4'd2 || state_o !== 2'b10) begin
            errors++;
            $display("FAIL collide_pause count=%0d state=%0d required 2 2", count, state_o);
        end
    endtask

    task automatic test_rst();
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        step(2);
        rst = 1'b1;
        cmd_op = OP_LOAD; cmd_lo = 4'd5; cmd_hi = 4'd7; cmd_valid = 1'b1;
        step(1);
        checks++;
        if (count !== 4'd0 || state_o !== 2'b00 || cmd_ready !== 1'b1 || dir !== 1'b1 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset count=%0d state=%0d ready=%b dir=%b err=%b required 0 0 1 1 0",
                     count, state_o, cmd_ready, dir, cmd_err);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        step(1);
    endtask

    task automatic test_bounds();
        sb_on = 1'b1;
        send_cmd(OP_LOAD, 4'd14, 4'd15, 1'b1, 1'b1);
        push(4'd15, 1'b1); push(4'd14, 1'b1); push(4'd15, 1'b1);
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_sb(200);
        send_cmd(OP_STOP, 4'd0, 4'd0, 1'b0, 1'b0);
        send_cmd(OP_LOAD, 4'd13, 4'd15, 1'b0, 1'b1);
        push(4'd14, 1'b1); push(4'd15, 1'b1); push(4'd14, 1'b0); push(4'd13, 1'b0);
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_sb(200);
        send_cmd(OP_STOP, 4'd0, 4'd0, 1'b0, 1'b0);
        send_cmd(OP_LOAD, 4'd7, 4'd7, 1'b0, 1'b1);
        push(4'd7, 1'b1); push(4'd7, 1'b1);
        send_cmd(OP_START, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_sb(200);
        send_cmd(OP_STOP, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd7 || dir !== 1'b1 || state_o !== 2'b00) begin
            errors++;
            $display("FAIL lo_eq_hi count=%0d dir=%b state=%0d required 7 1 0", count, dir, state_o);
        end
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_start();
        test_bounce();
        test_wrap();
        test_reject();
        test_pause_en();
        test_collision();
        test_rst();
        test_bounds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout time=%0t required finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/updown_counter_ctrl.md
Name: updown_counter_ctrl

Overview:
- Command-driven sequencer for the team's 4-bit up/down bounce counter datapath.
- Single clock domain. It derives a one-cycle tick enable internally; there is no divided clock.
- Holds programmable lower/upper bounds, direction and mode (bounce or wrap).
- Accepts START/PAUSE/STOP/LOAD commands from a host over a valid/ready handshake, and exposes count and status.

Parameters:
- WIDTH, 4, counter width in bits.
- DIV, 100000000, clk cycles per count tick (DIV ≥ 1).
- DIV_W, 28, prescaler width (must hold DIV-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- en  in  1  count enable. Low freezes the prescaler and count while in RUN.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_op  in  2  00 STOP, 01 START, 10 PAUSE, 11 LOAD.
- cmd_lo  in  WIDTH  LOAD: lower bound.
- cmd_hi  in  WIDTH  LOAD: upper bound.
- cmd_wrap  in  1  LOAD: 1 = wrap mode, 0 = bounce mode.
- cmd_dir  in  1  LOAD: initial direction, 1 = up.
- count  out  WIDTH  current count (registered).
- dir  out  1  current direction, 1 = up.
- tick  out  1  one-cycle pulse on the cycle count updates.
- state_o  out  2  00 IDLE, 01 RUN, 10 PAUSE.
- cmd_err  out  1  one-cycle pulse: command rejected.

Behaviour:
- Reset values: state IDLE, count 0, lo 0, hi 2^WIDTH-1, dir 1, wrap 0, prescaler 0, tick 0, cmd_ready 1, cmd_err 0.
- Handshake:
  - Accept occurs when cmd_valid & cmd_ready at a rising edge.
  - cmd_ready deasserts for exactly one cycle after each accept, then returns high.
  - Command effects are visible the cycle after accept.
- Prescaler:
  - Counts 0..DIV-1 only in RUN with en=1.
  - tick=1 in the cycle where prescaler==DIV-1, and count updates at that same edge.
  - Prescaler wraps to 0 after DIV-1.
  - Cleared on STOP, START-from-IDLE and LOAD. Retained across PAUSE and en low.
- FSM:
  - IDLE: START → RUN; LOAD → IDLE (applies config); STOP → IDLE; PAUSE → rejected.
  - RUN: PAUSE → PAUSE; STOP → IDLE; START → ignored (no error); LOAD → rejected.
  - PAUSE: START → RUN (prescaler resumes from held value); STOP → IDLE; PAUSE → ignored; LOAD → rejected.
  - A rejected command is still consumed and pulses cmd_err; state and config are unchanged.
- STOP: count := lo, dir := cfg_dir, state IDLE.
- LOAD:
  - If cmd_lo > cmd_hi: rejected (cmd_err), nothing changes.
  - Otherwise: lo, hi, wrap and cfg_dir are stored; dir := cmd_dir; count := cmd_lo.
- Tick update, bounce mode:
  - Up and count==hi: dir := 0, count := hi-1.
  - Down and count==lo: dir := 1, count := lo+1.
  - Otherwise count ±1 per dir.
- Tick update, wrap mode:
  - Up and count==hi: count := lo.
  - Down and count==lo: count := hi.
  - dir never changes.
- lo==hi: count holds at lo on every tick, dir is unchanged, and tick still pulses.
- Arithmetic is modulo 2^WIDTH but never leaves [lo,hi]. The full range lo=0, hi=15 must not overflow.
- Simultaneous command accept and tick edge: the command wins.
  - STOP/PAUSE suppress the count update; tick is still 0 in that cycle.
  - START in RUN lets the tick proceed.
- rst mid-operation returns all state to reset values on the next edge, regardless of cmd_valid.

Optional Feature:
- Macro: UDC_REVERSAL_IRQ_EN.
- When defined, adds ports irq (out, 1) and irq_clr (in, 1).
  - irq sets sticky on any tick that reverses dir (bounce) or wraps (wrap mode).
  - irq clears on irq_clr=1. If set and clear happen in the same cycle, set wins.
  - irq resets to 0.
- When undefined: no irq or irq_clr ports, and no related logic.

Test Plan:
- DIV=4, WIDTH=4. Reset, then START → state_o=01. First tick 4 cycles after START takes effect; count 0→1→2, ticks every 4 clk.
- LOAD lo=3 hi=5 bounce dir=1, then START → count sequence 3,4,5,4,3,4 with dir flipping at 5 and 3.
- LOAD lo=2 hi=4 wrap dir=0, then START → count 2,4,3,2,4; dir stays 0.
- LOAD lo=9 hi=5 → cmd_err pulse; lo/hi/count unchanged. LOAD issued while in RUN → cmd_err; counting continues.
- In RUN at prescaler=2: PAUSE → count frozen; hold 10 cycles, START → next tick exactly 1 cycle later. en=0 for 8 cycles in RUN → no tick.
- PAUSE accepted on the tick cycle → count unchanged. rst asserted mid-RUN → count=0, state_o=00, cmd_ready=1 next cycle.
